// File: rtl/mig_params.sv
// -----------------------------------------------------------------------------
// mig_params
// Shared constants and types for the iAFU page-migration path. The snoop event
// type is common to the AFU snooper (producer) and the snoop tracker
// (consumer).
// -----------------------------------------------------------------------------
package mig_params;

    localparam int MIG_GRP_SIZE   = 4;   // migration page slots tracked
    localparam int NUM_SNP_PORTS  = 4;   // ch0 AR, ch1 AR, ch0 AW, ch1 AW
    localparam int LINES_PER_PAGE = 64;  // 64 B lines in a 4 KB page

    localparam int IDXW = $clog2(MIG_GRP_SIZE);
    localparam int OFFW = $clog2(LINES_PER_PAGE);
    localparam int CNTW = $clog2(LINES_PER_PAGE + 1);  // must hold 0..64

    // One snoop event lane: valid, line offset within the page, slot hit.
    typedef struct packed {
        logic            inv;
        logic [OFFW-1:0] pg_off;
        logic [IDXW-1:0] idx;
    } t_iafu_snp_evt;

    // Read-and-clear response payload.
    typedef struct packed {
        logic [LINES_PER_PAGE-1:0] bitmap;
        logic [CNTW-1:0]           count;
        logic                      idle;
    } t_trk_rd_rsp;

    // Number of set bits in a page bitmap.
    function automatic logic [CNTW-1:0] popcount(input logic [LINES_PER_PAGE-1:0] v);
        logic [CNTW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < LINES_PER_PAGE; i++) begin
            cnt = cnt + CNTW'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/iafu_snp_tracker_if.sv
// -----------------------------------------------------------------------------
// iafu_snp_tracker_if
// Bundles the snoop event lanes, the arm command, the read-and-clear
// request/response handshake and the per-slot armed flags.
//   slave  : the tracker side (consumes events/requests, drives responses)
//   master : the snooper + migration engine side
// -----------------------------------------------------------------------------
interface iafu_snp_tracker_if
    import mig_params::*;
#(
    parameter int MIG_GRP_SIZE   = mig_params::MIG_GRP_SIZE,
    parameter int NUM_SNP_PORTS  = mig_params::NUM_SNP_PORTS,
    parameter int LINES_PER_PAGE = mig_params::LINES_PER_PAGE
);
    localparam int IDXW = $clog2(MIG_GRP_SIZE);

    // Snoop event lanes
    logic [NUM_SNP_PORTS-1:0]           iafu_snp_inv;
    logic [NUM_SNP_PORTS-1:0][OFFW-1:0] iafu_snp_pg_off;
    logic [NUM_SNP_PORTS-1:0][IDXW-1:0] iafu_snp_idx;

    // Arm command (always accepted)
    logic            arm_valid;
    logic [IDXW-1:0] arm_idx;

    // Read-and-clear request
    logic            rd_req_valid;
    logic [IDXW-1:0] rd_req_idx;
    logic            rd_req_last;
    logic            rd_req_ready;

    // Read response
    logic                      rd_rsp_valid;
    logic                      rd_rsp_ready;
    logic [LINES_PER_PAGE-1:0] rd_rsp_bitmap;
    logic [CNTW-1:0]           rd_rsp_count;
    logic                      rd_rsp_idle;

    // Per-slot armed flags
    logic [MIG_GRP_SIZE-1:0] trk_armed;

    modport slave (
        input  iafu_snp_inv, iafu_snp_pg_off, iafu_snp_idx,
        input  arm_valid, arm_idx,
        input  rd_req_valid, rd_req_idx, rd_req_last,
        output rd_req_ready,
        output rd_rsp_valid, rd_rsp_bitmap, rd_rsp_count, rd_rsp_idle,
        input  rd_rsp_ready,
        output trk_armed
    );

    modport master (
        output iafu_snp_inv, iafu_snp_pg_off, iafu_snp_idx,
        output arm_valid, arm_idx,
        output rd_req_valid, rd_req_idx, rd_req_last,
        input  rd_req_ready,
        input  rd_rsp_valid, rd_rsp_bitmap, rd_rsp_count, rd_rsp_idle,
        output rd_rsp_ready,
        input  trk_armed
    );

endinterface

// File: rtl/iafu_snp_trk_slot.sv
// -----------------------------------------------------------------------------
// iafu_snp_trk_slot
// One migration slot: armed flag, 64-bit touched-line bitmap and the merge of
// this cycle's snoop events that hit the slot.
// Ports:
//   afu_clk, afu_rstn : clock, async active-low reset
//   evt               : all snoop lanes (each lane filtered on idx here)
//   arm               : clear bitmap and start tracking (wins over everything)
//   rd_clr, rd_last   : read handshake targets this slot; disarm after it
//   armed             : slot is tracking
//   snap              : bitmap | this cycle's events (what a read captures)
// -----------------------------------------------------------------------------
module iafu_snp_trk_slot
    import mig_params::*;
#(
    parameter int SLOT_ID        = 0,
    parameter int NUM_SNP_PORTS  = mig_params::NUM_SNP_PORTS,
    parameter int LINES_PER_PAGE = mig_params::LINES_PER_PAGE
) (
    input  logic                               afu_clk,
    input  logic                               afu_rstn,
    input  t_iafu_snp_evt [NUM_SNP_PORTS-1:0]  evt,
    input  logic                               arm,
    input  logic                               rd_clr,
    input  logic                               rd_last,
    output logic                               armed,
    output logic [LINES_PER_PAGE-1:0]          snap
);

    logic [LINES_PER_PAGE-1:0] bitmap_q;
    logic [LINES_PER_PAGE-1:0] evt_mask;

    // Duplicate lanes simply set the same bit again.
    always_comb begin
        // NOTE: every variable written in an always_comb gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        evt_mask = '0;
        for (int l = 0; l < NUM_SNP_PORTS; l++) begin
            if (evt[l].inv && (evt[l].idx == IDXW'(SLOT_ID))) begin
                evt_mask[evt[l].pg_off] = 1'b1;
            end
        end
    end

    // Events to an idle slot are dropped here.
    assign snap = armed ? (bitmap_q | evt_mask) : '0;

    // NOTE: the bitmap is a small flop array rather than a RAM, so it takes
    // the async reset directly; a RAM-mapped store would need an init sweep.
    always_ff @(posedge afu_clk or negedge afu_rstn) begin
        if (!afu_rstn) begin
            armed    <= 1'b0;
            bitmap_q <= '0;
        end else if (arm) begin
            // Arm overrides a same-cycle read (incl. rd_last) and any events.
            armed    <= 1'b1;
            bitmap_q <= '0;
        end else if (rd_clr) begin
            // Same-cycle events were folded into the snapshot, so drop them.
            bitmap_q <= '0;
            if (rd_last) begin
                armed <= 1'b0;
            end
        end else begin
            bitmap_q <= snap;
        end
    end

endmodule

// File: rtl/iafu_snp_tracker.sv
// -----------------------------------------------------------------------------
// iafu_snp_tracker
// Tracks which 64 B lines of each page under migration were touched while the
// copy was in flight. The migration engine arms a slot when its copy starts
// and later read-and-clears the slot bitmap to find lines to re-copy.
// Ports:
//   afu_clk   : clock
//   afu_rstn  : async active-low reset (release synchronised internally)
//   trk       : iafu_snp_tracker_if.slave
//               snoop lanes, arm_valid/arm_idx,
//               rd_req_valid/idx/last/ready, rd_rsp_valid/ready/bitmap/
//               count/idle, trk_armed
// One read is outstanding at a time: response the cycle after the request
// handshake, held until rd_rsp_ready.
// -----------------------------------------------------------------------------
module iafu_snp_tracker
    import mig_params::*;
#(
    parameter int MIG_GRP_SIZE   = mig_params::MIG_GRP_SIZE,
    parameter int NUM_SNP_PORTS  = mig_params::NUM_SNP_PORTS,
    parameter int LINES_PER_PAGE = mig_params::LINES_PER_PAGE
) (
    input  logic               afu_clk,
    input  logic               afu_rstn,
    iafu_snp_tracker_if.slave  trk
);

    localparam int IDXW = $clog2(MIG_GRP_SIZE);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RSP  = 1'b1
    } t_rsp_state;

    // Reset: asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_pipe_q;
    logic       rst_n;

    always_ff @(posedge afu_clk or negedge afu_rstn) begin
        if (!afu_rstn) begin
            rst_pipe_q <= 2'b00;
        end else begin
            // NOTE: sequential state always uses <=, so every flop samples the
            // pre-edge value and this shift chain really is two stages deep.
            rst_pipe_q <= {rst_pipe_q[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe_q[1];

    // Snoop lanes repacked into the shared event type.
    t_iafu_snp_evt [NUM_SNP_PORTS-1:0] evt;

    always_comb begin
        evt = '0;
        for (int l = 0; l < NUM_SNP_PORTS; l++) begin
            evt[l].inv    = trk.iafu_snp_inv[l];
            evt[l].pg_off = trk.iafu_snp_pg_off[l];
            evt[l].idx    = trk.iafu_snp_idx[l];
        end
    end

    t_rsp_state state_q, state_d;
    logic       req_ready;
    logic       rsp_valid;
    logic       req_hs;

    logic [MIG_GRP_SIZE-1:0]                     armed;
    logic [MIG_GRP_SIZE-1:0][LINES_PER_PAGE-1:0] snap;
    logic [LINES_PER_PAGE-1:0]                   snap_sel;

    assign req_hs = trk.rd_req_valid && req_ready;

    for (genvar s = 0; s < MIG_GRP_SIZE; s++) begin : g_slot
        iafu_snp_trk_slot #(
            .SLOT_ID        (s),
            .NUM_SNP_PORTS  (NUM_SNP_PORTS),
            .LINES_PER_PAGE (LINES_PER_PAGE)
        ) u_slot (
            .afu_clk  (afu_clk),
            .afu_rstn (rst_n),
            .evt      (evt),
            .arm      (trk.arm_valid && (trk.arm_idx == IDXW'(s))),
            .rd_clr   (req_hs && (trk.rd_req_idx == IDXW'(s))),
            .rd_last  (trk.rd_req_last),
            .armed    (armed[s]),
            .snap     (snap[s])
        );
    end

    assign snap_sel = snap[trk.rd_req_idx];

    // Response FSM
    always_ff @(posedge afu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (trk.rd_req_valid) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (trk.rd_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Response payload, loaded only on the request handshake so it stays
    // stable for as long as the consumer stalls.
    t_trk_rd_rsp rsp_q;

    always_ff @(posedge afu_clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else if (req_hs) begin
            rsp_q.bitmap <= snap_sel;
            rsp_q.count  <= popcount(snap_sel);
            rsp_q.idle   <= !armed[trk.rd_req_idx];
        end
    end

    assign trk.rd_req_ready  = req_ready;
    assign trk.rd_rsp_valid  = rsp_valid;
    assign trk.rd_rsp_bitmap = rsp_q.bitmap;
    assign trk.rd_rsp_count  = rsp_q.count;
    assign trk.rd_rsp_idle   = rsp_q.idle;
    assign trk.trk_armed     = armed;

endmodule

// File: doc/iafu_snp_tracker.md
Name: iafu_snp_tracker

Overview:
- Consumer of the page-snoop event stream produced per cycle by the AFU snooper: up to 4 events, each carrying a valid, a 6-bit line offset and a migration-group slot index.
- Keeps a 64-bit touched-line bitmap per migration slot.
- The migration engine arms a slot when page copy starts, then read-and-clears the bitmap to find the lines it must re-copy.
- Sits between the snooper and the migration control FSM in the iAFU.

Parameters:
- MIG_GRP_SIZE, 4, number of migration page slots tracked.
- NUM_SNP_PORTS, 4, snoop event lanes per cycle (ch0 AR, ch1 AR, ch0 AW, ch1 AW).
- LINES_PER_PAGE, 64, 64 B lines per 4 KB page; sets bitmap width.
- IDXW, $clog2(MIG_GRP_SIZE), slot index width (derived, not overridable).

Ports:
- afu_clk  in  1  clock
- afu_rstn  in  1  reset; asynchronous, active-low
- iafu_snp_inv[NUM_SNP_PORTS]  in  1  event valid per lane
- iafu_snp_pg_off[NUM_SNP_PORTS]  in  6  line offset within page
- iafu_snp_idx[NUM_SNP_PORTS]  in  IDXW  slot hit
- arm_valid  in  1  arm (clear + start tracking) slot arm_idx; always accepted
- arm_idx  in  IDXW  slot to arm
- rd_req_valid  in  1  read-and-clear request
- rd_req_idx  in  IDXW  slot to read
- rd_req_last  in  1  disarm slot after this read
- rd_req_ready  out  1  request accepted when valid&ready
- rd_rsp_valid  out  1  response valid
- rd_rsp_ready  in  1  response consumed
- rd_rsp_bitmap  out  LINES_PER_PAGE  touched lines snapshot
- rd_rsp_count  out  7  popcount of rd_rsp_bitmap (0..64)
- rd_rsp_idle  out  1  slot was not armed at capture
- trk_armed  out  MIG_GRP_SIZE  per-slot armed flag

Behaviour:
- Reset (async assert; release is synchronised by the top level): all bitmaps 0, trk_armed 0, rd_req_ready 1, rd_rsp_valid 0, rd_rsp_bitmap 0, rd_rsp_count 0, rd_rsp_idle 0. A reset during S_RSP drops rd_rsp_valid immediately and discards the response.
- Slot states: IDLE, ARMED.
  - arm_valid: slot goes ARMED and its bitmap is cleared next edge. An arm on an already-ARMED slot re-clears it.
  - A read handshake with rd_req_last=1: slot goes IDLE after capture.
- Event update: each cycle, for each lane with inv=1 whose slot is ARMED, bitmap[idx][pg_off] is set.
  - Events to IDLE slots are dropped.
  - Duplicate lanes (same idx and off) are idempotent.
  - Lanes hitting different slots update in parallel.
- Response FSM:
  - S_IDLE: rd_req_ready=1. On rd_req_valid: capture snapshot = bitmap[idx] | this cycle's events to idx (only if ARMED), compute popcount, set idle flag = !armed, clear bitmap[idx]. Go to S_RSP.
  - S_RSP: rd_req_ready=0. rd_rsp_valid=1 with outputs held stable until rd_rsp_ready, then return to S_IDLE.
  - Latency: rsp_valid is asserted the cycle after the request handshake. Maximum throughput is 1 read per 2 cycles.
- Simultaneous events, same slot, same cycle:
  - Read capture and events: events go into the snapshot and are not retained in the bitmap (no loss, no double report).
  - Read capture and arm: snapshot reflects pre-arm contents plus events; bitmap ends 0; slot ARMED (arm overrides rd_req_last).
  - Arm and events without read: arm wins, bitmap 0, events discarded.
- Events arriving during S_RSP accumulate normally into the live bitmap.
- Width: popcount result is 7 bits unsigned; 64 set bits gives 7'd64.

Decomposition:
- Shared package (mig_params):
  - MIG_GRP_SIZE and LINES_PER_PAGE constants.
  - typedef t_iafu_snp_evt {inv; pg_off[5:0]; idx}, shared with the snooper.
  - typedef t_trk_rd_rsp {bitmap; count; idle}.
- One sub-module, iafu_snp_trk_slot: per-slot armed flag, bitmap and event-merge logic, instantiated MIG_GRP_SIZE times. The response FSM and popcount stay in the top level.

Test Plan:
- Arm slot 2; lane0 off=5 idx=2, lane3 off=63 idx=2 in one cycle; read slot 2 -> bitmap bits 5 and 63 set, count=2, idle=0. An immediate second read -> bitmap 0, count 0.
- Event to unarmed slot 1 (off=7), then arm slot 1 and read -> count 0. A read of an never-armed slot 3 -> idle=1, bitmap 0.
- Arm slot 0; read slot 0 in the same cycle as lane1 off=9 idx=0 -> snapshot bit 9, count 1; next read -> count 0.
- Hold rd_rsp_ready=0 for 5 cycles with events streaming to the read slot -> rsp fields stable and rd_req_ready=0. After the ready handshake, the next read returns the streamed events.
- Arm slot 0, set all 64 offsets over 16 cycles (4 lanes) -> count=64. Read with rd_req_last=1 -> trk_armed[0]=0; a later event to slot 0 is dropped.
- Assert afu_rstn low asynchronously mid-S_RSP -> rd_rsp_valid drops before the next edge, trk_armed=0, and a read after release returns idle=1.
